// File: rtl/divider_pkg.sv
// Shared constants and helpers for the divider datapath.
// Direction/mode encodings and the load clamp used by step_counter.
package divider_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Out-of-range load values are pinned to the top of the legal range.
  function automatic logic [31:0] clamp_to_max(input logic [31:0] value,
                                               input logic [31:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/step_unit.sv
// Combinational single-step unit: next count value and boundary flag.
// Boundary is checked before stepping, so raw carry/borrow never escapes.
module step_unit
  import divider_pkg::*;
#(
  parameter int          WIDTH = 4,
  parameter int unsigned MAX   = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0] cur_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] next_o,
  output logic             boundary_o
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

  always_comb begin
    next_o     = cur_i;
    boundary_o = 1'b0;
    if (up_i == DIR_UP) begin
      boundary_o = (cur_i == MaxVal);
      next_o     = boundary_o ? '0 : cur_i + 1'b1;
    end else begin
      boundary_o = (cur_i == '0);
      next_o     = boundary_o ? MaxVal : cur_i - 1'b1;
    end
  end

endmodule

// File: rtl/step_counter.sv
// Bidirectional modulo counter with load, wrap/saturate mode, terminal-count
// flag and a registered wrap pulse; used as the divider iteration counter.
module step_counter
  import divider_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter int unsigned MAX      = 2**WIDTH-1,
  parameter int          SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] step_next;
  logic             at_boundary;

  step_unit #(
    .WIDTH (WIDTH),
    .MAX   (MAX)
  ) u_step (
    .cur_i      (out_q),
    .up_i       (up),
    .next_o     (step_next),
    .boundary_o (at_boundary)
  );

  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    if (load) begin
      out_d = WIDTH'(clamp_to_max(32'(load_val), 32'(MAX)));
    end else if (enable) begin
      // In saturate mode the boundary still raises wrap to flag the overrun.
      wrap_d = at_boundary;
      out_d  = (at_boundary && SATURATE == MODE_SAT) ? out_q : step_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign wrap = wrap_q;
  assign tc   = at_boundary;

endmodule
